// File: rtl/regfile_pkg.sv
// Shared register-file constants and types for datapath pipeline fields.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package regfile_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_COUNT  = 1 << REG_ADDR_W;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [31:0]           reg_word_t;

  localparam reg_addr_t ZERO_ADDR = '0;

  // True for the hardwired-zero register.
  function automatic logic is_zero_addr(input reg_addr_t addr);
    return addr == ZERO_ADDR;
  endfunction

endpackage

// File: rtl/regfile_word.sv
// One storage word: WIDTH-bit register with load enable and async clear.
// Latency: load visible on q one clk edge after en=1.
// Backpressure: none; a load is always accepted when en=1 and reset is high.
module regfile_word #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Hold the word; cleared asynchronously while reset is low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/regfile_2r1w.sv
// Two-read one-write architectural register file; word 0 reads as zero.
// Latency: write lands on the next clk edge; reads are combinational.
// Backpressure: none; the write port is always ready, reads never stall.
// Build option: define REGFILE_BYPASS_EN to forward wr_data to a matching read.
module regfile_2r1w
  import regfile_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [WIDTH-1:0]  rd_data1,
  output logic [WIDTH-1:0]  rd_data2
);

  localparam int NWORDS = 1 << ADDR_W;

  // Word 0 has no storage; its slot is tied to zero so the read mux
  // needs no special case.
  logic [WIDTH-1:0]  words [NWORDS];
  logic [NWORDS-1:1] wr_sel;

  assign words[0] = '0;

  // One-hot write decode. Each select is ANDed with wr_en so an unknown
  // enable can only reach the addressed word, never its neighbours.
  always_comb begin
    wr_sel = '0;
    for (int i = 1; i < NWORDS; i++) begin
      wr_sel[i] = wr_en & (wr_addr == ADDR_W'(i));
    end
  end

  for (genvar i = 1; i < NWORDS; i++) begin : g_word
    regfile_word #(
      .WIDTH (WIDTH)
    ) u_word (
      .clk   (clk),
      .reset (reset),
      .en    (wr_sel[i]),
      .d     (wr_data),
      .q     (words[i])
    );
  end

`ifdef REGFILE_BYPASS_EN
  // A write is forwardable only when it would actually commit at the edge.
  logic byp_ok;
  assign byp_ok = wr_en & reset & (wr_addr != '0);
`endif

  // Read muxes, with optional same-cycle forwarding of the write data.
  always_comb begin
    rd_data1 = words[rd_addr1];
    rd_data2 = words[rd_addr2];
`ifdef REGFILE_BYPASS_EN
    if (byp_ok && (rd_addr1 == wr_addr)) rd_data1 = wr_data;
    if (byp_ok && (rd_addr2 == wr_addr)) rd_data2 = wr_data;
`endif
  end

endmodule

// File: tb/tb_regfile_2r1w.sv
// Self-checking bench for regfile_2r1w: a reference array tracks committed
// writes, expected read values are queued as stimulus is applied and popped
// when the read ports are sampled. Works with or without REGFILE_BYPASS_EN.
module tb_regfile_2r1w;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [4:0]  rd_addr1;
  logic [4:0]  rd_addr2;
  logic [31:0] rd_data1;
  logic [31:0] rd_data2;

  always #5 clk = ~clk;

  regfile_2r1w #(
    .WIDTH  (32),
    .ADDR_W (5)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_addr1 (rd_addr1),
    .rd_addr2 (rd_addr2),
    .rd_data1 (rd_data1),
    .rd_data2 (rd_data2)
  );

  int n_chk = 0;
  int n_err = 0;

  logic [31:0] mdl [32];

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q [$];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic push_exp(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    exp_q.push_back(e);
  endtask

  task automatic pop_chk(input logic [31:0] act);
    exp_t e;
    if (exp_q.size() == 0) begin
      chk("sb_underflow", 32'(exp_q.size()), 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk(e.tag, act, e.val);
    end
  endtask

  function automatic logic [31:0] mval(input logic [4:0] a);
    return (a == 5'd0) ? 32'h0 : mdl[a];
  endfunction

  function automatic logic [31:0] pat(input logic [4:0] a);
    logic [39:0] t;
    t = {4{a, ~a}};
    return t[31:0];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
  endtask

  // Sample both ports now (inputs applied, 1 time unit to settle).
  task automatic read_now(input string tag, input logic [4:0] a1, input logic [4:0] a2);
    rd_addr1 = a1;
    rd_addr2 = a2;
    push_exp({tag, "_p1"}, mval(a1));
    push_exp({tag, "_p2"}, mval(a2));
    #1;
    pop_chk(rd_data1);
    pop_chk(rd_data2);
  endtask

  task automatic read_pair(input string tag, input logic [4:0] a1, input logic [4:0] a2);
    @(negedge clk);
    read_now(tag, a1, a2);
  endtask

  task automatic do_write(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    @(posedge clk);
    if (reset && a != 5'd0) mdl[a] = d;
    #1;
    wr_en = 1'b0;
  endtask

  initial begin
    reset    = 1'b0;
    wr_en    = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    rd_addr1 = '0;
    rd_addr2 = '0;
    model_reset();

    // Reset state on a spread of addresses.
    repeat (2) @(negedge clk);
    for (int a = 0; a < 32; a += 7) read_now("rst_init", 5'(a), 5'(31 - a));
    @(negedge clk);
    reset = 1'b1;

    // Reset clears r5 asynchronously and keeps it clear after release.
    do_write(5'd5, 32'hDEADBEEF);
    read_pair("w_r5", 5'd5, 5'd5);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    read_now("rst_low", 5'd5, 5'd5);
    repeat (2) @(posedge clk);
    @(negedge clk);
    read_now("rst_hold", 5'd5, 5'd5);
    reset = 1'b1;
    read_now("rst_rel", 5'd5, 5'd5);

    // Basic write then read.
    do_write(5'd3, 32'h12345678);
    read_pair("basic", 5'd3, 5'd0);

    // Writes to r0 are discarded; neighbours untouched.
    do_write(5'd1, 32'hA5A5A5A5);
    do_write(5'd31, 32'hA5A5A5A5);
    do_write(5'd0, 32'hFFFFFFFF);
    read_pair("zero", 5'd0, 5'd0);
    read_pair("nbr", 5'd1, 5'd31);

    // Same-address read during write on r7.
    do_write(5'd7, 32'h11111111);
    @(negedge clk);
    wr_en    = 1'b1;
    wr_addr  = 5'd7;
    wr_data  = 32'h22222222;
    rd_addr1 = 5'd7;
    rd_addr2 = 5'd3;
`ifdef REGFILE_BYPASS_EN
    push_exp("rw_before", 32'h22222222);
`else
    push_exp("rw_before", 32'h11111111);
`endif
    push_exp("rw_other", 32'h12345678);
    #1;
    pop_chk(rd_data1);
    pop_chk(rd_data2);
    @(posedge clk);
    mdl[7] = 32'h22222222;
    #1;
    read_now("rw_after", 5'd7, 5'd7);
    wr_en = 1'b0;
    read_now("rw_idle", 5'd7, 5'd3);

    // Reset falls half a cycle before an edge carrying a write to r9.
    do_write(5'd9, 32'h99999999);
    @(negedge clk);
    wr_en    = 1'b1;
    wr_addr  = 5'd9;
    wr_data  = 32'hCAFEF00D;
    rd_addr1 = 5'd9;
    rd_addr2 = 5'd9;
`ifdef REGFILE_BYPASS_EN
    push_exp("arst_pre_p1", 32'hCAFEF00D);
    push_exp("arst_pre_p2", 32'hCAFEF00D);
`else
    push_exp("arst_pre_p1", 32'h99999999);
    push_exp("arst_pre_p2", 32'h99999999);
`endif
    #1;
    pop_chk(rd_data1);
    pop_chk(rd_data2);
    reset = 1'b0;
    model_reset();
    read_now("arst_low", 5'd9, 5'd9);
    @(posedge clk);
    #1;
    read_now("arst_edge", 5'd9, 5'd9);
    wr_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    read_now("arst_rel", 5'd9, 5'd9);

    // Back-to-back writes to r12: the second wins.
    @(negedge clk);
    wr_en   = 1'b1;
    wr_addr = 5'd12;
    wr_data = 32'hAAAA0001;
    @(posedge clk);
    mdl[12] = 32'hAAAA0001;
    #1;
    wr_data = 32'hBBBB0002;
    @(posedge clk);
    mdl[12] = 32'hBBBB0002;
    #1;
    wr_en = 1'b0;
    read_pair("b2b", 5'd12, 5'd12);

    // Unknown write enable must leave every other word alone. Target data
    // equals its current contents so either resolution of the enable agrees.
    do_write(5'd4, 32'h44444444);
    do_write(5'd5, 32'h55555555);
    @(negedge clk);
    wr_en    = 1'bx;
    wr_addr  = 5'd4;
    wr_data  = 32'h44444444;
    rd_addr1 = 5'd5;
    @(posedge clk);
    #1;
    assert (rd_data1 == 32'h55555555)
      else $error("FAIL xen_assert: r5 got %h expected 55555555", rd_data1);
    read_now("xen", 5'd5, 5'd4);
    wr_en = 1'b0;

    // Full sweep with address-dependent pattern.
    for (int a = 1; a < 32; a++) do_write(5'(a), pat(5'(a)));
    for (int i = 0; i < 32; i++) read_pair("sweep", 5'(i), 5'(31 - i));

    chk("sb_drain", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
